// File: rtl/snk_pix_shift_seq.sv
// Pixel-shift / line-buffer sequencer for the SNK-style video path.
// Optional horizontal flip support is enabled by defining SNK_PIX_FLIP_EN.
module snk_pix_shift_seq #(
    parameter int PIX_BITS   = 3,
    parameter int BANKS      = 2,
    parameter int LATCH_STEP = 3,
    parameter int CEN_EDGE   = 1
) (
    input  logic                     clk,
    input  logic                     Reset_n,
    input  logic                     Cen,
    input  logic                     line_start,
    input  logic                     hblank,
    input  logic                     flip,
    output logic [PIX_BITS-1:0]      pix_cnt,
    output logic                     load_n,
    output logic                     vlk,
    output logic                     shift_dir,
    output logic [$clog2(BANKS)-1:0] wr_bank,
    output logic [$clog2(BANKS)-1:0] rd_bank,
    output logic                     clr_we
);

    localparam int BW = $clog2(BANKS);

    logic                last_cen;
    logic                pend;
    logic                tick;
    logic                ls;
    logic [PIX_BITS-1:0] step;
    logic [PIX_BITS-1:0] step_next;
    logic [BW-1:0]       wr_inc;
    logic [BW-1:0]       rd_inc;

    // Edge mode blocks a tick on the first clk after reset via last_cen=1
    assign tick      = (CEN_EDGE != 0) ? (Cen & ~last_cen) : Cen;
    assign ls        = line_start | pend;
    assign step_next = step + 1'b1;
    assign wr_inc    = (wr_bank == BW'(BANKS - 1)) ? '0 : wr_bank + 1'b1;
    assign rd_inc    = (wr_inc == BW'(BANKS - 1)) ? '0 : wr_inc + 1'b1;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_cen <= 1'b1;
            pend     <= 1'b0;
            clr_we   <= 1'b0;
        end else begin
            last_cen <= Cen;
            clr_we   <= tick & ~hblank;
            if (tick)
                pend <= 1'b0;
            else if (line_start)
                pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            step    <= '0;
            load_n  <= 1'b1;
            vlk     <= 1'b0;
            wr_bank <= '0;
            rd_bank <= BW'(1);
        end else if (tick) begin
            if (ls) begin
                step    <= '0;
                wr_bank <= wr_inc;
                rd_bank <= rd_inc;
                load_n  <= 1'b0;
                vlk     <= (LATCH_STEP == 0);
            end else begin
                step    <= step_next;
                load_n  <= ~(step_next == '0);
                vlk     <= (step_next == PIX_BITS'(LATCH_STEP));
            end
        end
    end

`ifdef SNK_PIX_FLIP_EN
    logic flip_q;

    // Flip is only honoured at a line boundary
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n)
            flip_q <= 1'b0;
        else if (tick && ls)
            flip_q <= flip;
    end

    assign pix_cnt   = flip_q ? ~step : step;
    assign shift_dir = flip_q;
`else
    logic flip_unused;

    assign flip_unused = flip;
    assign pix_cnt     = step;
    assign shift_dir   = 1'b0;
`endif

endmodule
